// File: rtl/bgd_div_seq_14s_if.sv
// Operand/result handshake bundle for the bgd_div_seq_14s divider.
// The remainder signal exists only when BGD_DIV_REM_EN is defined.
interface bgd_div_seq_14s_if #(
  parameter int WIDTH = 14
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] dividend;
  logic signed [WIDTH-1:0] divisor;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] quotient;
`ifdef BGD_DIV_REM_EN
  logic signed [WIDTH-1:0] remainder;
`endif
  logic                    div_by_zero;
  logic                    overflow;

`ifdef BGD_DIV_REM_EN
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
`else
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, div_by_zero, overflow
  );
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, div_by_zero, overflow
  );
`endif
endinterface

// File: rtl/bgd_div_seq_14s.sv
// Sequential radix-2 restoring signed divider, one quotient bit per enabled cycle.
// Optional feature macro: BGD_DIV_REM_EN adds the signed remainder output.
module bgd_div_seq_14s #(
  parameter int WIDTH = 14
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ce,
  bgd_div_seq_14s_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] rem_acc;
  logic [WIDTH-2:0] q_acc;
  logic             dvd_neg;
  logic             neg_q;
  logic             dz_pend;
  logic             ov_pend;

  logic [WIDTH-1:0] dvd_in;
  logic [WIDTH-1:0] dvs_in;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] q_res;
  logic             accept;

  always_comb begin
    next_state    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (ce && bus.in_valid) next_state = CALC;
      end
      CALC: begin
        if (ce && counter == '0) next_state = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (ce && bus.out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)   state <= IDLE;
    else if (ce) state <= next_state;
  end

  // One restoring step: the borrow bit of the trial subtraction decides the quotient bit.
  always_comb begin
    dvd_in   = bus.dividend;
    dvs_in   = bus.divisor;
    accept   = ce && bus.in_valid && (state == IDLE);
    shifted  = {rem_acc, dvd_mag[counter]};
    diff     = shifted - {1'b0, dvs_mag};
    ge       = ~diff[WIDTH];
    rem_next = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    q_next   = {q_acc, ge};
    q_res    = neg_q ? (~q_next + 1'b1) : q_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter         <= '0;
      rem_acc         <= '0;
      q_acc           <= '0;
      dvd_mag         <= '0;
      dvs_mag         <= '0;
      dvd_neg         <= 1'b0;
      neg_q           <= 1'b0;
      dz_pend         <= 1'b0;
      ov_pend         <= 1'b0;
      bus.quotient    <= '0;
`ifdef BGD_DIV_REM_EN
      bus.remainder   <= '0;
`endif
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
    end else if (ce) begin
      if (accept) begin
        // MIN's magnitude 2^(WIDTH-1) still fits in WIDTH unsigned bits.
        dvd_mag <= dvd_in[WIDTH-1] ? (~dvd_in + 1'b1) : dvd_in;
        dvs_mag <= dvs_in[WIDTH-1] ? (~dvs_in + 1'b1) : dvs_in;
        dvd_neg <= dvd_in[WIDTH-1];
        neg_q   <= dvd_in[WIDTH-1] ^ dvs_in[WIDTH-1];
        dz_pend <= (dvs_in == '0);
        ov_pend <= (dvd_in == MIN_VAL) && (dvs_in == '1);
        counter <= CNT_W'(WIDTH - 1);
        rem_acc <= '0;
        q_acc   <= '0;
      end else if (state == CALC) begin
        rem_acc <= rem_next;
        q_acc   <= q_next[WIDTH-2:0];
        if (counter == '0) begin
          bus.quotient    <= dz_pend ? (dvd_neg ? MIN_VAL : MAX_VAL) : q_res;
`ifdef BGD_DIV_REM_EN
          if (dz_pend)
            bus.remainder <= dvd_neg ? (~dvd_mag + 1'b1) : dvd_mag;
          else
            bus.remainder <= dvd_neg ? (~rem_next + 1'b1) : rem_next;
`endif
          bus.div_by_zero <= dz_pend;
          bus.overflow    <= ov_pend;
        end else begin
          counter <= counter - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bgd_div_seq_14s.sv
// Directed self-checking bench for bgd_div_seq_14s with hand-computed results.
// Remainder checks are compiled in only when BGD_DIV_REM_EN is defined.
module tb_bgd_div_seq_14s;

  localparam int WIDTH = 14;

  logic clk;
  logic reset;
  logic ce;
  int   checks;
  int   errors;

  bgd_div_seq_14s_if #(.WIDTH(WIDTH)) bus ();

  bgd_div_seq_14s #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Waits (bounded) for in_ready, presents operands for one edge, then scrambles them.
  task automatic applyStimulus(input int dvd, input int dvs);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("in_ready_before_send", bus.in_ready, 1);
    bus.dividend = 14'(dvd);
    bus.divisor  = 14'(dvs);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.dividend = 14'h1555;
    bus.divisor  = 14'h2aaa;
  endtask

  // Counts enabled edges after the accepting edge until out_valid shows up.
  task automatic waitResult(input bit toggle_ce, output int lat);
    logic en;
    lat = 0;
    for (int i = 0; i < 100 && !bus.out_valid; i++) begin
      if (toggle_ce) ce = ~ce;
      en = ce;
      @(posedge clk);
      #1;
      if (en) lat++;
    end
    ce = 1'b1;
  endtask

  task automatic runDivision(input int dvd, input int dvs, input bit toggle_ce,
                             input int exp_q, input int exp_r, input bit exp_dz,
                             input bit exp_ov, input bit release_out);
    int    lat;
    string nm;
    nm = $sformatf("%0d/%0d", dvd, dvs);
    applyStimulus(dvd, dvs);
    waitResult(toggle_ce, lat);
    checkOutput({nm, " latency"}, lat, 14);
    checkOutput({nm, " quotient"}, bus.quotient, exp_q);
`ifdef BGD_DIV_REM_EN
    checkOutput({nm, " remainder"}, bus.remainder, exp_r);
`else
    if (exp_r > 16384) $display("[TB] note: remainder out of range for %s", nm);
`endif
    checkOutput({nm, " div_by_zero"}, bus.div_by_zero, exp_dz);
    checkOutput({nm, " overflow"}, bus.overflow, exp_ov);
    checkOutput({nm, " in_ready_done"}, bus.in_ready, 0);
    if (release_out) begin
      @(posedge clk);
      #1;
      checkOutput({nm, " back_to_idle"}, {bus.in_ready, bus.out_valid}, 2'b10);
    end
  endtask

  initial begin
    int lat;
    int bad;
    checks        = 0;
    errors        = 0;
    ce            = 1'b1;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset in_ready", bus.in_ready, 1);
    checkOutput("reset out_valid", bus.out_valid, 0);
    checkOutput("reset quotient", bus.quotient, 0);
    checkOutput("reset div_by_zero", bus.div_by_zero, 0);
    checkOutput("reset overflow", bus.overflow, 0);
`ifdef BGD_DIV_REM_EN
    checkOutput("reset remainder", bus.remainder, 0);
`endif
    reset = 1'b0;

    runDivision(  100,  7, 1'b0,    14,    2, 1'b0, 1'b0, 1'b1);
    runDivision( -100,  7, 1'b0,   -14,   -2, 1'b0, 1'b0, 1'b1);
    runDivision(  100, -7, 1'b0,   -14,    2, 1'b0, 1'b0, 1'b1);
    runDivision( 1234,  0, 1'b0,  8191, 1234, 1'b1, 1'b0, 1'b1);
    runDivision(   -5,  0, 1'b0, -8192,   -5, 1'b1, 1'b0, 1'b1);
    runDivision(-8192, -1, 1'b0, -8192,    0, 1'b0, 1'b1, 1'b1);
    runDivision( 8191,  1, 1'b0,  8191,    0, 1'b0, 1'b0, 1'b1);

    // Backpressure: result held while out_ready is low, new operands refused.
    bus.out_ready = 1'b0;
    runDivision(-300, 17, 1'b0, -17, -11, 1'b0, 1'b0, 1'b0);
    bus.dividend = 14'(77);
    bus.divisor  = 14'(5);
    bus.in_valid = 1'b1;
    bad = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (!bus.out_valid || bus.in_ready || bus.quotient !== -14'sd17 ||
          bus.div_by_zero || bus.overflow) bad++;
    end
    checkOutput("backpressure stable", bad, 0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp release idle", {bus.in_ready, bus.out_valid}, 2'b10);
    @(posedge clk);
    #1;
    checkOutput("bp next accepted", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    bus.dividend = 14'h1555;
    bus.divisor  = 14'h2aaa;
    waitResult(1'b0, lat);
    checkOutput("77/5 latency", lat, 14);
    checkOutput("77/5 quotient", bus.quotient, 15);
`ifdef BGD_DIV_REM_EN
    checkOutput("77/5 remainder", bus.remainder, 2);
`endif
    @(posedge clk);
    #1;

    // Clock enable alternating during the division.
    runDivision(50, 3, 1'b1, 16, 2, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a division discards it.
    applyStimulus(100, 7);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("midreset in_ready", bus.in_ready, 1);
    checkOutput("midreset out_valid", bus.out_valid, 0);
    checkOutput("midreset quotient", bus.quotient, 0);
    checkOutput("midreset div_by_zero", bus.div_by_zero, 0);
    checkOutput("midreset overflow", bus.overflow, 0);
`ifdef BGD_DIV_REM_EN
    checkOutput("midreset remainder", bus.remainder, 0);
`endif
    runDivision(9, 4, 1'b0, 2, 1, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
